// File: rtl/imem_prefetch.sv
// Instruction prefetch buffer: holds up to DEPTH consecutive words ahead of the PC,
// answers hits combinationally and flushes/restarts on any out-of-window fetch address.
module imem_prefetch #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] im_addr_i,
   output logic [31:0] im_dout_o,
   output logic        im_busy_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [OW:0] MAXO_W  = (OW + 1)'(MAX_OUTSTANDING);

   logic [31:0]   r_base;
   logic [31:0]   r_nfa;
   logic [PW-1:0] r_head;
   logic [CW-1:0] r_count;
   logic [OW-1:0] r_live;
   logic [OW-1:0] r_discard;
   logic [31:0]   r_data [DEPTH];

   logic [29:0]   w_k;
   logic [29:0]   w_count30;
   logic [29:0]   w_fill30;
   logic          w_hit;
   logic          w_room;
   logic          w_pending;
   logic          w_miss;
   logic          w_slot_ok;
   logic          w_req;
   logic          w_grant;
   logic          w_rv;
   logic          w_drop;
   logic          w_keep;
   logic [CW-1:0] w_adv;
   logic [PW-1:0] w_rd_idx;
   logic [PW-1:0] w_wr_idx;
   logic          w_unused_lsb;

   assign w_unused_lsb = ^im_addr_i[1:0];

   assign w_k       = im_addr_i[31:2] - r_base[31:2];
   assign w_count30 = 30'(r_count);
   assign w_fill30  = 30'(r_count) + 30'(r_live);
   assign w_hit     = (w_k < w_count30);
   assign w_room    = (w_fill30 < DEPTH_W);
   // The word at nfa counts as pending when it can still be requested; otherwise a
   // freshly flushed buffer (count=live=0) would re-miss forever.
   assign w_pending = !w_hit && ((w_k < w_fill30) || ((w_k == w_fill30) && w_room));
   assign w_miss    = !w_hit && !w_pending;
   assign w_slot_ok = (({1'b0, r_live} + {1'b0, r_discard}) < MAXO_W);

   assign w_req   = rst_n_i && !w_miss && w_room && w_slot_ok;
   assign w_grant = w_req && mem_gnt_i;
   assign w_rv    = rst_n_i && mem_rvalid_i && !w_miss;
   assign w_drop  = w_rv && (r_discard != '0);
   assign w_keep  = w_rv && (r_discard == '0) && (r_live != '0);

   assign w_adv    = w_hit ? w_k[CW-1:0] : '0;
   assign w_rd_idx = r_head + w_k[PW-1:0];
   assign w_wr_idx = r_head + r_count[PW-1:0];

   assign im_busy_o  = !(rst_n_i && w_hit);
   assign im_dout_o  = (rst_n_i && w_hit) ? r_data[w_rd_idx] : '0;
   assign mem_req_o  = w_req;
   assign mem_addr_o = r_nfa;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_base    <= '0;
         r_nfa     <= '0;
         r_head    <= '0;
         r_count   <= '0;
         r_live    <= '0;
         r_discard <= '0;
      end else if (w_miss) begin
         r_base    <= {im_addr_i[31:2], 2'b00};
         r_nfa     <= {im_addr_i[31:2], 2'b00};
         r_count   <= '0;
         r_live    <= '0;
         // Everything still in flight becomes discard, minus a response landing right now.
         r_discard <= r_discard + r_live
                      - OW'(mem_rvalid_i && ((r_discard != '0) || (r_live != '0)));
      end else begin
         if (w_hit) begin
            r_base <= {im_addr_i[31:2], 2'b00};
         end
         r_head    <= r_head + w_adv[PW-1:0];
         r_count   <= r_count - w_adv + CW'(w_keep);
         r_live    <= r_live + OW'(w_grant) - OW'(w_keep);
         r_discard <= r_discard - OW'(w_drop);
         if (w_grant) begin
            r_nfa <= r_nfa + 32'd4;
         end
      end
   end

   // Slot is computed from pre-advance head/count, so it stays correct during a hit-advance.
   always_ff @(posedge clk_i) begin
      if (w_keep) begin
         r_data[w_wr_idx] <= mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: table-driven streaming vectors, directed corner sequences and a
// randomized run checked against an abstract memory/outstanding-request reference.
module tb_imem_prefetch;
   localparam int DEPTH = 4;
   localparam int MAXO  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] dout;
   logic        busy;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   imem_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .im_addr_i(pc), .im_dout_o(dout), .im_busy_o(busy),
      .mem_req_o(req), .mem_addr_o(addr), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
      .mem_rdata_i(rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int mem_lat  = 1;
   int gnt_mode = 0;   // 0: always grant, 1: random, 2: never
   int last_ready = 0;

   typedef struct { logic [31:0] data; int ready; } rsp_t;
   rsp_t        rq[$];
   logic [31:0] glog[$];

   typedef struct {
      logic [31:0] pc;
      logic        busy;
      logic [31:0] dout;
      logic        req;
      logic [31:0] addr;
   } vec_t;
   vec_t tbl[18];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'hC0DE_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d pc=%h actual=%h required=%h", name, cyc, pc, act, exp);
      end
   endtask

   // Drive memory-side inputs, then at the falling edge check against the reference.
   task automatic step_begin();
      if (!rst_n) begin
         gnt = 1'b0; rvalid = 1'b0; rdata = '0;
         @(negedge clk);
         chk("reset_busy", 32'(busy), 32'd1);
         chk("reset_dout", dout, 32'd0);
         chk("reset_req", 32'(req), 32'd0);
         return;
      end
      gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rq.size() > 0 && rq[0].ready <= cyc) begin
         rvalid = 1'b1; rdata = rq[0].data;
      end else begin
         rvalid = 1'b0; rdata = $urandom;
      end
      @(negedge clk);
      if (!busy) chk("hit_data", dout, memfn(pc));
      else       chk("busy_dout_zero", dout, 32'd0);
      if (req && gnt) begin
         rsp_t r;
         chk("outstanding_limit", 32'(rq.size() < MAXO), 32'd1);
         r.data  = memfn(addr);
         r.ready = (cyc + mem_lat > last_ready) ? cyc + mem_lat : last_ready + 1;
         last_ready = r.ready;
         rq.push_back(r);
         glog.push_back(addr);
      end
      if (rvalid) void'(rq.pop_front());
   endtask

   task automatic step_end();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      step_begin();
      step_end();
   endtask

   task automatic do_reset(input logic [31:0] rpc);
      rst_n = 1'b0;
      pc    = rpc;
      rq.delete();
      glog.delete();
      last_ready = 0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int streak;
      logic [31:0] held;
      logic [31:0] nxt;
      int r;

      rst_n = 1'b0; pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      @(posedge clk); #1;

      // Streaming from reset: req 0x0 at t+1, 0x4 at t+2, first hit at t+3, then no stalls.
      for (int i = 0; i < 18; i++) begin
         tbl[i].pc   = (i <= 2) ? 32'd0 : 32'(4 * (i - 2));
         tbl[i].busy = (i < 2);
         tbl[i].dout = (i < 2) ? 32'd0 : memfn(tbl[i].pc);
         tbl[i].req  = 1'b1;
         tbl[i].addr = 32'(4 * i);
      end
      mem_lat = 1; gnt_mode = 0;
      do_reset(32'd0);
      for (int i = 0; i < 18; i++) begin
         pc = tbl[i].pc;
         step_begin();
         chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
         chk("tbl_dout", dout, tbl[i].dout);
         chk("tbl_req", 32'(req), 32'(tbl[i].req));
         chk("tbl_addr", addr, tbl[i].addr);
         step_end();
      end

      // Flush with two requests live: both responses are dropped.
      mem_lat = 3;
      do_reset(32'h8);
      repeat (3) step();
      chk("live_count", 32'(glog.size()), 32'd2);
      if (glog.size() == 2) begin
         chk("live_addr0", glog[0], 32'h8);
         chk("live_addr1", glog[1], 32'hC);
      end
      glog.delete();
      pc = 32'h100;
      n = 0;
      step();
      while (busy && n < 30) begin step(); n++; end
      chk("flush_unbusy", 32'(busy), 32'd0);
      chk("flush_first_word", dout, memfn(32'h100));
      chk("flush_req_count_ok", 32'(glog.size() >= 1), 32'd1);
      if (glog.size() >= 1) chk("flush_first_req", glog[0], 32'h100);

      // Hold PC at 0x8: buffer fills to DEPTH, then requests stop.
      mem_lat = 1;
      glog.delete();
      pc = 32'h8;
      repeat (12) step();
      step_begin();
      chk("hold_req_off", 32'(req), 32'd0);
      chk("hold_dout", dout, memfn(32'h8));
      chk("hold_fill", 32'(glog.size()), 32'(DEPTH));
      step_end();

      // count=3, base=0x20, then PC=0x28 hits and advances by two.
      glog.delete();
      pc = 32'h20;
      n = 0;
      while (glog.size() < 3 && n < 12) begin step(); n++; end
      gnt_mode = 2;
      repeat (2) step();
      pc = 32'h28;
      step_begin();
      chk("adv_hit_busy", 32'(busy), 32'd0);
      chk("adv_hit_dout", dout, memfn(32'h28));
      step_end();
      step_begin();
      chk("adv_base_busy", 32'(busy), 32'd0);
      chk("adv_base_dout", dout, memfn(32'h28));
      step_end();
      pc = 32'h2C;
      step_begin();
      chk("adv_count_busy", 32'(busy), 32'd1);
      chk("adv_count_req", 32'(req), 32'd1);
      chk("adv_count_addr", addr, 32'h2C);
      step_end();
      gnt_mode = 0;

      // Miss near the top of memory: fetch wraps to 0x0.
      glog.delete();
      pc = 32'hFFFF_FFF8;
      repeat (5) step();
      chk("wrap_req_count_ok", 32'(glog.size() >= 3), 32'd1);
      if (glog.size() >= 3) begin
         chk("wrap_req0", glog[0], 32'hFFFF_FFF8);
         chk("wrap_req1", glog[1], 32'hFFFF_FFFC);
         chk("wrap_req2", glog[2], 32'h0000_0000);
      end

      // Randomized core and memory behaviour.
      gnt_mode = 1;
      streak = 0;
      held = pc;
      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) begin
            do_reset(32'h40);
            held = pc;
            streak = 0;
         end
         mem_lat = $urandom_range(1, 3);
         step_begin();
         streak = (busy && pc == held) ? streak + 1 : 0;
         held = pc;
         chk("progress", 32'(streak <= 40), 32'd1);
         r = $urandom_range(0, 99);
         nxt = pc;
         if ((!busy && r >= 80) || (busy && r < 5)) begin
            case ($urandom_range(0, 3))
               0: nxt = 32'($urandom_range(0, 255));
               1: nxt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
               2: nxt = pc - 32'(4 * $urandom_range(0, 3));
               default: nxt = pc + 32'(4 * $urandom_range(0, 5));
            endcase
         end else if (!busy && r < 65) begin
            nxt = pc + 32'd4;
         end
         step_end();
         pc = nxt;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
